// File: rtl/uart_tx_engine.sv
// UART transmitter: start bit, DBIT data bits LSB first, SB_TICK-long stop period.
// Bit timing comes from an external 16x oversampling tick; the serial line is registered.
module uart_tx_engine #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_start,
    input  logic            s_tick,
    input  logic [DBIT-1:0] din,
    output logic            tx_done_tick,
    output logic            tx_busy,
    output logic            tx
);

    // Tick counter must also reach SB_TICK-1 for 1.5/2 stop bits.
    localparam int unsigned SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int unsigned NW = $clog2(DBIT);

    localparam logic [SW-1:0] BitLast  = SW'(15);
    localparam logic [SW-1:0] StopLast = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] NLast    = NW'(DBIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            tx_q, tx_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        b_d          = b_q;
        tx_done_tick = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tx_start) begin
                    b_d     = din;
                    s_d     = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (s_tick) begin
                    if (s_q == BitLast) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = StData;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (s_tick) begin
                    if (s_q == BitLast) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == NLast) begin
                            state_d = StStop;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (s_tick) begin
                    if (s_q == StopLast) begin
                        tx_done_tick = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level follows the state being entered so tx changes with the state.
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = b_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign tx_busy = (state_q != StIdle);
    assign tx      = tx_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: per-clock waveform model for tied-high ticks and a
// tick-counting loopback receiver for divided or random ticks.
module tb_uart_tx_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tx_start = 1'b0;
    logic       s_tick = 1'b0;
    logic [7:0] din = '0;
    logic       tx_done_tick, tx_busy, tx;

    logic       tx_start2 = 1'b0;
    logic [6:0] din2 = '0;
    logic       done2, busy2, tx2;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int tick_mode = 0;

    uart_tx_engine #(.DBIT(8), .SB_TICK(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_start     (tx_start),
        .s_tick       (s_tick),
        .din          (din),
        .tx_done_tick (tx_done_tick),
        .tx_busy      (tx_busy),
        .tx           (tx)
    );

    uart_tx_engine #(.DBIT(7), .SB_TICK(32)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .tx_start     (tx_start2),
        .s_tick       (s_tick),
        .din          (din2),
        .tx_done_tick (done2),
        .tx_busy      (busy2),
        .tx           (tx2)
    );

    always #5 clk = ~clk;

    // 0: tied high, 1: every 4th clk, other: random ~1/3 density
    initial begin : tick_gen
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            case (tick_mode)
                0: s_tick = 1'b1;
                1: begin
                    s_tick = (cnt == 3);
                    cnt = (cnt + 1) % 4;
                end
                default: s_tick = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    // Line level i clocks after acceptance of one frame; idle-high outside it.
    function automatic logic exp_level(input logic [8:0] d, input int dbit, input int i);
        if (i < 16) return 1'b0;
        if (i < 16 * (1 + dbit)) return d[(i - 16) / 16];
        return 1'b1;
    endfunction

    function automatic int first_diff(input logic [1023:0] a, input logic [1023:0] b);
        for (int i = 0; i < 1024; i++) begin
            if (a[i] !== b[i]) return i;
        end
        return -1;
    endfunction

    // Sends d0 (d1 for a held-start second frame), samples n clocks from acceptance.
    task automatic capture(input string name, input bit sel, input logic [8:0] d0,
                           input logic [8:0] d1, input bit hold, input int inject_at,
                           input int n, input int nframes);
        int dbit, sbt, len, f, r, k;
        logic [1023:0] gtx, gb, gd, etx, eb, ed;
        dbit = sel ? 7 : 8;
        sbt  = sel ? 32 : 16;
        len  = 16 * (1 + dbit) + sbt;
        gtx = '0; gb = '0; gd = '0; etx = '0; eb = '0; ed = '0;
        for (int i = 0; i < n; i++) begin
            f = i / (len + 1);
            r = i % (len + 1);
            if (f < nframes && r < len) begin
                etx[i] = exp_level((f == 0) ? d0 : d1, dbit, r);
                eb[i]  = 1'b1;
                ed[i]  = (r == len - 1);
            end else begin
                etx[i] = 1'b1;
            end
        end
        tick_mode = 0;
        @(posedge clk);
        #1;
        if (sel) begin tx_start2 = 1'b1; din2 = d0[6:0]; end
        else begin tx_start = 1'b1; din = d0[7:0]; end
        @(posedge clk);
        #1;
        if (!hold) begin tx_start = 1'b0; tx_start2 = 1'b0; end
        din  = d1[7:0];
        din2 = d1[6:0];
        for (int i = 0; i < n; i++) begin
            if (i == inject_at) begin
                tx_start = 1'b1; tx_start2 = 1'b1; din = 8'hFF; din2 = 7'h7F;
            end else if (i == inject_at + 1 || (hold && i == nframes * (len + 1) - 1)) begin
                tx_start = 1'b0; tx_start2 = 1'b0;
            end
            @(negedge clk);
            gtx[i] = sel ? tx2 : tx;
            gb[i]  = sel ? busy2 : tx_busy;
            gd[i]  = sel ? done2 : tx_done_tick;
            @(posedge clk);
            #1;
        end
        tx_start = 1'b0;
        tx_start2 = 1'b0;
        chk_cnt++;
        k = first_diff(gtx, etx);
        if (gtx !== etx) $display("FAIL %s tx: clk %0d got %b expected %b", name, k, gtx[k], etx[k]);
        else pass_cnt++;
        chk_cnt++;
        k = first_diff(gb, eb);
        if (gb !== eb) $display("FAIL %s tx_busy: clk %0d got %b expected %b", name, k, gb[k], eb[k]);
        else pass_cnt++;
        chk_cnt++;
        k = first_diff(gd, ed);
        if (gd !== ed) $display("FAIL %s tx_done_tick: clk %0d got %b expected %b", name, k, gd[k], ed[k]);
        else pass_cnt++;
    endtask

    // Receiver that counts s_tick: samples mid start bit, then every 16 ticks.
    task automatic loopback(input string name, input logic [7:0] d, input int mode,
                            input int exp_gap);
        int tk, c, idx, rise_c, fall_c, done_cnt;
        bit started, fin;
        logic prev, start_lvl, stop_lvl;
        logic [7:0] rx;
        tk = 0; c = 0; idx = 0; rise_c = -1; fall_c = -1; done_cnt = 0;
        started = 0; fin = 0; prev = 1'b1; start_lvl = 1'b1; stop_lvl = 1'b0; rx = '0;
        tick_mode = mode;
        @(posedge clk);
        #1;
        din = d;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        din = ~d;
        while (!fin && c < 4000) begin
            @(negedge clk);
            c++;
            if (tx_done_tick === 1'b1) done_cnt++;
            if (!started && tx === 1'b0) started = 1;
            if (started && s_tick) begin
                tk++;
                if (tk == 8) start_lvl = tx;
                else if (tk > 8 && (tk - 8) % 16 == 0) begin
                    idx = (tk - 8) / 16;
                    if (idx <= 8) rx[idx - 1] = tx;
                    else if (idx == 9) stop_lvl = tx;
                end
            end
            if (prev === 1'b0 && tx === 1'b1 && rise_c < 0) rise_c = c;
            else if (prev === 1'b1 && tx === 1'b0 && rise_c >= 0 && fall_c < 0) fall_c = c;
            prev = tx;
            if (started && tx_busy === 1'b0) fin = 1;
        end
        tick_mode = 0;
        chk_cnt++;
        if (!fin) $display("FAIL %s timeout: frame not finished after %0d clks", name, c);
        else pass_cnt++;
        chk_cnt++;
        if (start_lvl !== 1'b0) $display("FAIL %s start bit: got %b expected 0", name, start_lvl);
        else pass_cnt++;
        chk_cnt++;
        if (rx !== d) $display("FAIL %s data: got %h expected %h", name, rx, d);
        else pass_cnt++;
        chk_cnt++;
        if (stop_lvl !== 1'b1) $display("FAIL %s stop bit: got %b expected 1", name, stop_lvl);
        else pass_cnt++;
        chk_cnt++;
        if (done_cnt != 1) $display("FAIL %s done pulses: got %0d expected 1", name, done_cnt);
        else pass_cnt++;
        if (exp_gap >= 0) begin
            chk_cnt++;
            if (fall_c - rise_c != exp_gap)
                $display("FAIL %s two-bit duration: got %0d expected %0d", name, fall_c - rise_c,
                         exp_gap);
            else pass_cnt++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int bad;
        #1 reset = 1'b1;
        #1;
        chk_cnt++;
        if ({tx, tx_busy, tx_done_tick} !== 3'b100)
            $display("FAIL reset_init: tx/busy/done got %b expected 100", {tx, tx_busy, tx_done_tick});
        else pass_cnt++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick_mode = 0;
        din = 8'h00;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk_cnt++;
        if (tx !== 1'b0) $display("FAIL reset_pre: tx mid-data got %b expected 0", tx);
        else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        chk_cnt++;
        if (tx !== 1'b1) $display("FAIL reset_async tx: got %b expected 1", tx);
        else pass_cnt++;
        chk_cnt++;
        if (tx_busy !== 1'b0) $display("FAIL reset_async tx_busy: got %b expected 0", tx_busy);
        else pass_cnt++;
        chk_cnt++;
        if (tx_done_tick !== 1'b0) $display("FAIL reset_async done: got %b expected 0", tx_done_tick);
        else pass_cnt++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done_tick !== 1'b0) bad++;
        end
        chk_cnt++;
        if (bad != 0) $display("FAIL reset_after: %0d bad idle clks, expected 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_basic_frame();
        capture("basic_55", 1'b0, 9'h055, 9'($urandom), 1'b0, -10, 164, 1);
    endtask

    task automatic test_divided_tick();
        loopback("divided_a3", 8'hA3, 1, 128);
    endtask

    task automatic test_ignored_request();
        capture("ignored_12", 1'b0, 9'h012, 9'h012, 1'b0, 60, 200, 1);
    endtask

    task automatic test_back_to_back();
        capture("back_to_back", 1'b0, 9'h00F, 9'h0F0, 1'b1, -10, 2 * 161 + 6, 2);
    endtask

    task automatic test_stop_length();
        capture("stop32_7f", 1'b1, 9'h07F, 9'h000, 1'b0, -10, 164, 1);
    endtask

    task automatic test_random_frames();
        logic [8:0] d;
        for (int k = 0; k < 4; k++) begin
            d = 9'($urandom);
            capture("random_frame", k[0], d, 9'($urandom), 1'b0, -10, 164, 1);
        end
    endtask

    task automatic test_random_ticks();
        for (int k = 0; k < 3; k++) loopback("random_ticks", 8'($urandom), 2, -1);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_divided_tick();
        test_ignored_request();
        test_back_to_back();
        test_stop_length();
        test_random_frames();
        test_random_ticks();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
